common_cross_buffern_arbited: RTL and testbench

COMMON_CROSS_BUFFERN_ARBITED -- requirements
Module: common_cross_buffern_arbited

---
 rtl/common_cross_buffern_arbited.sv | 97 +++++++++
 tb/tb_common_cross_buffern_arbited.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/common_cross_buffern_arbited.sv
// N-to-1 arbitrated FIFO: grants one upstream channel per cycle (fixed priority
// or round-robin) and queues {source, data} entries in acceptance order.
module common_cross_buffern_arbited #(
  parameter int BUFFER_WIDTH  = 32,
  parameter int CHANNEL_COUNT = 4,
  parameter int BUFFER_DEPTH  = 4,
  parameter int ARBITER_MODE  = 0
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [CHANNEL_COUNT*BUFFER_WIDTH-1:0]   prev_i_data,
  input  logic [CHANNEL_COUNT-1:0]                prev_i_valid,
  output logic [CHANNEL_COUNT-1:0]                prev_o_ready,
  output logic [BUFFER_WIDTH-1:0]                 next_o_data,
  output logic [$clog2(CHANNEL_COUNT)-1:0]        next_o_src,
  output logic                                    next_o_valid,
  input  logic                                    next_i_ready,
  output logic [$clog2(BUFFER_DEPTH):0]           o_count
);

  localparam int SRC_W = $clog2(CHANNEL_COUNT);
  localparam int PTR_W = $clog2(BUFFER_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [SRC_W-1:0]        src;
    logic [BUFFER_WIDTH-1:0] data;
  } entry_t;

  entry_t            mem [BUFFER_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [SRC_W-1:0]  last_grant;
  logic [SRC_W-1:0]  winner, rr_idx;
  logic              found, full, push, pop;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    winner = '0;
    rr_idx = '0;
    found  = 1'b0;
    if (ARBITER_MODE == 0) begin
      // Descending scan: the last hit is the lowest valid index.
      for (int i = CHANNEL_COUNT - 1; i >= 0; i--) begin
        if (prev_i_valid[i]) begin
          winner = SRC_W'(i);
          found  = 1'b1;
        end
      end
    end else begin
      // Descending offset scan: the last hit is the first valid channel after last_grant.
      for (int k = CHANNEL_COUNT; k >= 1; k--) begin
        rr_idx = SRC_W'((int'(last_grant) + k) % CHANNEL_COUNT);
        if (prev_i_valid[rr_idx]) begin
          winner = rr_idx;
          found  = 1'b1;
        end
      end
    end
  end

  assign full         = (count == CNT_W'(BUFFER_DEPTH));
  assign prev_o_ready = (!reset && found && !full) ? (CHANNEL_COUNT'(1) << winner) : '0;
  assign push         = |(prev_i_valid & prev_o_ready);
  assign next_o_valid = !reset && (count != '0);
  assign pop          = next_o_valid && next_i_ready;
  assign next_o_data  = mem[rd_ptr].data;
  assign next_o_src   = mem[rd_ptr].src;
  assign o_count      = count;

  // NOTE: storage has no reset; validity is tracked by count alone, so stale words are never shown.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {winner, prev_i_data[winner*BUFFER_WIDTH +: BUFFER_WIDTH]};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      last_grant <= SRC_W'(CHANNEL_COUNT - 1);
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + PTR_W'(1);
        last_grant <= winner;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_common_cross_buffern_arbited.sv
// Bench driving a fixed-priority and a round-robin instance with shared stimulus,
// each compared against a queue-based reference model.
module tb_common_cross_buffern_arbited;

  localparam int W = 32;
  localparam int N = 4;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N*W-1:0] prev_i_data = '0;
  logic [N-1:0]   prev_i_valid = '0;
  logic           next_i_ready = 1'b0;

  logic [N-1:0]   rdy0, rdy1;
  logic [W-1:0]   data0, data1;
  logic [1:0]     src0, src1;
  logic           vld0, vld1;
  logic [2:0]     cnt0, cnt1;

  int tests = 0;
  int fails = 0;

  // Reference model: one ordered queue of {src, data} and one last-grant per mode.
  logic [33:0] mq [2][$];
  int          lg [2];

  always #5 clk = ~clk;

  common_cross_buffern_arbited #(.BUFFER_WIDTH(W), .CHANNEL_COUNT(N), .BUFFER_DEPTH(D), .ARBITER_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .prev_i_data(prev_i_data), .prev_i_valid(prev_i_valid),
    .prev_o_ready(rdy0), .next_o_data(data0), .next_o_src(src0), .next_o_valid(vld0),
    .next_i_ready(next_i_ready), .o_count(cnt0));

  common_cross_buffern_arbited #(.BUFFER_WIDTH(W), .CHANNEL_COUNT(N), .BUFFER_DEPTH(D), .ARBITER_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .prev_i_data(prev_i_data), .prev_i_valid(prev_i_valid),
    .prev_o_ready(rdy1), .next_o_data(data1), .next_o_src(src1), .next_o_valid(vld1),
    .next_i_ready(next_i_ready), .o_count(cnt1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int mode, input logic [N-1:0] v, input int last);
    if (mode == 0) begin
      for (int i = 0; i < N; i++) if (v[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] get_rdy(input int m);   return m ? rdy1 : rdy0;   endfunction
  function automatic logic [W-1:0] get_data(input int m);  return m ? data1 : data0; endfunction
  function automatic logic [1:0]   get_src(input int m);   return m ? src1 : src0;   endfunction
  function automatic logic         get_vld(input int m);   return m ? vld1 : vld0;   endfunction
  function automatic logic [2:0]   get_cnt(input int m);   return m ? cnt1 : cnt0;   endfunction

  // One clock: check grants before the edge, advance the model, check the buffer after it.
  task automatic cycle();
    int w [2];
    #1;
    for (int m = 0; m < 2; m++) begin
      w[m] = (reset || mq[m].size() == D) ? -1 : pick(m, prev_i_valid, lg[m]);
      check($sformatf("ready_m%0d", m), get_rdy(m), (w[m] < 0) ? 64'd0 : (64'd1 << w[m]));
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        mq[m].delete();
        lg[m] = N - 1;
      end else begin
        if (mq[m].size() > 0 && next_i_ready) void'(mq[m].pop_front());
        if (w[m] >= 0) begin
          mq[m].push_back({2'(w[m]), prev_i_data[w[m]*W +: W]});
          lg[m] = w[m];
        end
      end
      check($sformatf("valid_m%0d", m), get_vld(m), mq[m].size() != 0);
      check($sformatf("count_m%0d", m), get_cnt(m), mq[m].size());
      if (mq[m].size() != 0) begin
        check($sformatf("data_m%0d", m), get_data(m), mq[m][0][31:0]);
        check($sformatf("src_m%0d", m), get_src(m), mq[m][0][33:32]);
      end
    end
    @(negedge clk);
  endtask

  task automatic set_data(input logic [31:0] base);
    for (int i = 0; i < N; i++) prev_i_data[i*W +: W] = base + 32'(i);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    prev_i_valid = '0;
    repeat (cycles) cycle();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    do_reset(2);
    check("reset_count_m0", cnt0, 0);
    check("reset_valid_m1", vld1, 0);

    // Fixed priority starves the higher channels; round-robin rotates.
    set_data(32'hA0);
    prev_i_valid = 4'hF;
    next_i_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("m0_grant_ch0", rdy0, 4'b0001);
      check("m1_grant_rot", rdy1, 4'b0001 << (k % 4));
      cycle();
    end
    check("m0_stream_src", src0, 0);
    check("m0_stream_data", data0, 32'hA0);

    // Fill from channel 2 with the sink stalled.
    do_reset(1);
    next_i_ready = 1'b0;
    prev_i_valid = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      set_data(32'h100 + 32'(k) * 16);
      cycle();
    end
    check("fill_count_m0", cnt0, 4);
    check("fill_count_m1", cnt1, 4);
    #1;
    check("full_ready_m0", rdy0, 0);

    // Full with a same-cycle pop: no push this cycle, push on the next.
    next_i_ready = 1'b1;
    prev_i_valid = 4'b0010;
    #1;
    check("full_pop_ready1", rdy0[1], 1'b0);
    cycle();
    check("after_pop_count", cnt0, 3);
    #1;
    check("after_pop_ready1", rdy0, 4'b0010);
    cycle();
    prev_i_valid = '0;
    repeat (4) cycle();

    // Mid-stream reset drops everything; round-robin restarts at channel 0.
    do_reset(1);
    next_i_ready = 1'b0;
    prev_i_valid = 4'b0001;
    set_data(32'h300);
    repeat (3) cycle();
    check("pre_reset_count", cnt1, 3);
    reset = 1'b1;
    cycle();
    check("post_reset_count", cnt1, 0);
    check("post_reset_valid", vld1, 0);
    reset = 1'b0;
    prev_i_valid = 4'hF;
    #1;
    check("post_reset_rr_grant", rdy1, 4'b0001);
    cycle();

    // Backpressure: head must hold for five stalled cycles.
    do_reset(1);
    set_data(32'h5A0);
    prev_i_valid = 4'hF;
    repeat (2) cycle();
    prev_i_valid = '0;
    repeat (5) cycle();
    next_i_ready = 1'b1;
    repeat (3) cycle();

    // Random traffic against the scoreboard, with occasional resets.
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 63) == 0);
      prev_i_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) prev_i_data[i*W +: W] = $urandom;
      next_i_ready = (k < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
